// File: rtl/pong_text_writer.sv
// Writes the 16-char pong status line "Score:DD Ball:B " into the text tile RAM.
// Ports: clk, reset (async active-low), update/dig0/dig1/ball in,
//        wr_en/wr_ready/wr_addr/wr_data tile-RAM write port, busy/done status.
module pong_text_writer #(
    parameter int ROW  = 0,
    parameter int COL0 = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update,
    input  logic [3:0]  dig0,
    input  logic [3:0]  dig1,
    input  logic [1:0]  ball,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [11:0] wr_addr,
    output logic [6:0]  wr_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [4:0] ROW_F    = 5'(ROW);
    localparam logic [6:0] COL_BASE = 7'(COL0);

    state_t     state, state_n;
    logic [3:0] index, index_n;
    logic       pending, pending_n;
    logic       boot, boot_n;
    logic       load;
    logic [3:0] cap_d1, cap_d0;
    logic [1:0] cap_ball;
    logic [6:0] ch;
    logic [6:0] col;

    function automatic logic [6:0] digit(input logic [3:0] v);
        return (v > 4'd9) ? 7'h3F : (7'h30 + {3'b000, v});
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            index    <= 4'd0;
            pending  <= 1'b1;
            boot     <= 1'b1;
            cap_d1   <= 4'd0;
            cap_d0   <= 4'd0;
            cap_ball <= 2'd0;
        end else begin
            state   <= state_n;
            index   <= index_n;
            pending <= pending_n;
            boot    <= boot_n;
            if (load) begin
                cap_d1   <= dig1;
                cap_d0   <= dig0;
                cap_ball <= ball;
            end
        end
    end

    // The first pass after reset keeps the zeroed capture registers
    // unless a real update arrives in that same cycle.
    always_comb begin
        state_n   = state;
        index_n   = index;
        pending_n = pending;
        boot_n    = boot;
        load      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (update || pending) begin
                    state_n   = S_WRITE;
                    index_n   = 4'd0;
                    pending_n = 1'b0;
                    boot_n    = 1'b0;
                    load      = update || !boot;
                end
            end
            S_WRITE: begin
                if (update) pending_n = 1'b1;
                if (wr_ready) begin
                    if (index == 4'd15) state_n = S_DONE;
                    else index_n = index + 4'd1;
                end
            end
            S_DONE: begin
                if (update) pending_n = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        ch = 7'h20;
        unique case (index)
            4'd0:  ch = 7'h53;
            4'd1:  ch = 7'h63;
            4'd2:  ch = 7'h6F;
            4'd3:  ch = 7'h72;
            4'd4:  ch = 7'h65;
            4'd5:  ch = 7'h3A;
            4'd6:  ch = digit(cap_d1);
            4'd7:  ch = digit(cap_d0);
            4'd8:  ch = 7'h20;
            4'd9:  ch = 7'h42;
            4'd10: ch = 7'h61;
            4'd11: ch = 7'h6C;
            4'd12: ch = 7'h6C;
            4'd13: ch = 7'h3A;
            4'd14: ch = 7'h30 + {5'b00000, cap_ball};
            4'd15: ch = 7'h20;
        endcase
    end

    assign col     = COL_BASE + {3'b000, index};
    assign wr_en   = (state == S_WRITE);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign wr_addr = wr_en ? {ROW_F, col} : 12'd0;
    assign wr_data = wr_en ? ch : 7'd0;

endmodule
